eth_tx_framer: RTL and testbench

- Transmit-side Ethernet MAC framer that sits directly upstream of crc32.
- Accepts frame bytes (DA..payload) on an AXI-Stream-style byte interface.
- Emits a GMII-style byte stream: preamble, SFD, data, zero padding to minimum size, and 4-byte FCS, followed by an enforced inter-frame gap.
- Owns the CRC state register and drives the combinational crc32 core through its i_byte / i_crc_state / o_crc_state / crc_out ports.

---
 rtl/eth_tx_framer.sv | 197 +++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// eth_tx_framer
//   Transmit-side Ethernet framer placed directly upstream of the combinational
//   crc32 core. Takes frame bytes (DA..payload) on a byte stream, and emits a
//   GMII-style stream: preamble, SFD, data, zero padding up to MIN_FRAME bytes,
//   the 4-byte FCS (LSB byte first), then an enforced inter-frame gap.
//   The CRC state register lives here; crc32 only computes the next state.
//
// Ports
//   clk, reset      clock; synchronous active-high reset (aborts any frame)
//   s_tdata/s_tvalid/s_tlast/s_tready   input byte stream
//   o_txd/o_tx_en/o_tx_er               registered GMII transmit outputs
//   o_crc_byte      byte fed to crc32 i_byte (combinational)
//   o_crc_state     CRC state register, to crc32 i_crc_state
//   i_crc_next      crc32 o_crc_state (state after absorbing o_crc_byte)
//   i_crc_out       crc32 crc_out (reflected, inverted FCS of o_crc_state)
//   dbg_state       current FSM state, for checkers
//
// Handshake: a byte moves on a rising clk edge where s_tvalid && s_tready.
// s_tready depends only on the FSM state (high in PAYLOAD and DRAIN), never
// on s_tvalid. Once s_tvalid is raised the source holds s_tdata/s_tlast
// stable until the transfer happens.
module eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [7:0]  o_txd,
    output logic        o_tx_en,
    output logic        o_tx_er,
    output logic [7:0]  o_crc_byte,
    output logic [31:0] o_crc_state,
    input  logic [31:0] i_crc_next,
    input  logic [31:0] i_crc_out,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DRAIN, IFG
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
    // IFG occupies IFG_BYTES-1 cycles; the IDLE cycle that follows (which
    // always precedes PREAMBLE) supplies the last idle byte on the wire.
    localparam logic [15:0] IFG_LAST = (IFG_BYTES >= 2) ? 16'(IFG_BYTES - 2) : 16'd0;
    localparam state_t      IFG_NEXT = (IFG_BYTES >= 2) ? IFG : IDLE;

    state_t      state, state_d;
    logic [15:0] byte_cnt, byte_cnt_d, byte_inc;
    logic [15:0] step_cnt, step_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs_reg, fcs_d;
    logic [7:0]  txd_d;
    logic        en_d, er_d;

    assign byte_inc    = byte_cnt + 16'd1;
    assign o_crc_state = crc_q;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= 16'd0;
            step_cnt <= 16'd0;
            crc_q    <= 32'hFFFF_FFFF;
            fcs_reg  <= 32'd0;
            o_txd    <= 8'h00;
            o_tx_en  <= 1'b0;
            o_tx_er  <= 1'b0;
        end else begin
            state    <= state_d;
            byte_cnt <= byte_cnt_d;
            step_cnt <= step_cnt_d;
            crc_q    <= crc_d;
            fcs_reg  <= fcs_d;
            o_txd    <= txd_d;
            o_tx_en  <= en_d;
            o_tx_er  <= er_d;
        end
    end

    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        step_cnt_d = step_cnt;
        crc_d      = crc_q;
        fcs_d      = fcs_reg;
        txd_d      = 8'h00;
        en_d       = 1'b0;
        er_d       = 1'b0;
        s_tready   = 1'b0;
        o_crc_byte = 8'h00;

        case (state)
            IDLE: begin
                // The waiting byte stays on the bus until PAYLOAD takes it.
                if (s_tvalid) begin
                    state_d    = PREAMBLE;
                    step_cnt_d = 16'd0;
                    byte_cnt_d = 16'd0;
                end
            end

            PREAMBLE: begin
                en_d = 1'b1;
                if (step_cnt < PRE_LAST) begin
                    txd_d      = 8'h55;
                    step_cnt_d = step_cnt + 16'd1;
                end else begin
                    txd_d      = 8'hD5;
                    crc_d      = 32'hFFFF_FFFF;
                    step_cnt_d = 16'd0;
                    byte_cnt_d = 16'd0;
                    state_d    = PAYLOAD;
                end
            end

            PAYLOAD: begin
                s_tready   = 1'b1;
                o_crc_byte = s_tdata;
                en_d       = 1'b1;
                if (s_tvalid) begin
                    txd_d = s_tdata;
                    crc_d = i_crc_next;
                    // Saturate so arbitrarily long frames cannot wrap the count.
                    if (byte_cnt < MIN_LEN) begin
                        byte_cnt_d = byte_inc;
                    end
                    if (s_tlast) begin
                        step_cnt_d = 16'd0;
                        state_d    = (byte_inc < MIN_LEN) ? PAD : FCS;
                    end
                end else begin
                    // Source ran dry mid-frame: poison the frame, skip the FCS.
                    er_d    = 1'b1;
                    state_d = DRAIN;
                end
            end

            PAD: begin
                en_d       = 1'b1;
                crc_d      = i_crc_next;
                byte_cnt_d = byte_inc;
                if (byte_inc >= MIN_LEN) begin
                    step_cnt_d = 16'd0;
                    state_d    = FCS;
                end
            end

            FCS: begin
                // crc_q already holds the last data/pad byte, so i_crc_out is
                // the final FCS on the first cycle; keep it for the other bytes.
                en_d       = 1'b1;
                step_cnt_d = step_cnt + 16'd1;
                case (step_cnt[1:0])
                    2'd0: begin
                        txd_d = i_crc_out[7:0];
                        fcs_d = i_crc_out;
                    end
                    2'd1:    txd_d = fcs_reg[15:8];
                    2'd2:    txd_d = fcs_reg[23:16];
                    default: begin
                        txd_d      = fcs_reg[31:24];
                        step_cnt_d = 16'd0;
                        state_d    = IFG_NEXT;
                    end
                endcase
            end

            DRAIN: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    step_cnt_d = 16'd0;
                    state_d    = IFG_NEXT;
                end
            end

            IFG: begin
                if (step_cnt >= IFG_LAST) begin
                    step_cnt_d = 16'd0;
                    state_d    = IDLE;
                end else begin
                    step_cnt_d = step_cnt + 16'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer
//   Bench for eth_tx_framer. Two instances: dut0 with padding disabled
//   (MIN_FRAME=0) for the "123456789" check vector, dut1 with defaults for the
//   rest. A behavioural crc32 core closes the CRC loop of each instance.
//   Expected wire images come from a table-driven CRC-32 model over the
//   payload plus padding.
module tb_eth_tx_framer;

    localparam int PRE  = 7;
    localparam int MINF = 60;
    localparam int IFG  = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus / DUT wiring ----------------
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       sel = 1'b0;   // 0: drive/observe dut0, 1: dut1

    logic        ready0, en0, er0, ready1, en1, er1;
    logic [7:0]  txd0, cbyte0, txd1, cbyte1;
    logic [31:0] cstate0, cnext0, cout0, cstate1, cnext1, cout1;
    logic [2:0]  dbg0, dbg1;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    assign cnext0 = crc_step(cstate0, cbyte0);
    assign cout0  = ~cstate0;
    assign cnext1 = crc_step(cstate1, cbyte1);
    assign cout1  = ~cstate1;

    eth_tx_framer #(.PREAMBLE_LEN(PRE), .MIN_FRAME(0), .IFG_BYTES(IFG)) dut0 (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid & ~sel), .s_tlast(s_tlast), .s_tready(ready0),
        .o_txd(txd0), .o_tx_en(en0), .o_tx_er(er0),
        .o_crc_byte(cbyte0), .o_crc_state(cstate0), .i_crc_next(cnext0), .i_crc_out(cout0),
        .dbg_state(dbg0)
    );

    eth_tx_framer #(.PREAMBLE_LEN(PRE), .MIN_FRAME(MINF), .IFG_BYTES(IFG)) dut1 (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid & sel), .s_tlast(s_tlast), .s_tready(ready1),
        .o_txd(txd1), .o_tx_en(en1), .o_tx_er(er1),
        .o_crc_byte(cbyte1), .o_crc_state(cstate1), .i_crc_next(cnext1), .i_crc_out(cout1),
        .dbg_state(dbg1)
    );

    logic       m_ready, m_en, m_er;
    logic [7:0] m_txd;
    assign m_ready = sel ? ready1 : ready0;
    assign m_en    = sel ? en1 : en0;
    assign m_er    = sel ? er1 : er0;
    assign m_txd   = sel ? txd1 : txd0;

    // ---------------- monitor: split the wire into bursts ----------------
    logic [7:0] byte_q[$];
    int len_q[$], gap_q[$], er_q[$];
    int run_len = 0, idle_run = 0, er_run = 0, stray_er = 0;
    bit in_burst = 0;
    logic [7:0] seen0 = 8'h00, seen1 = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            seen0[dbg0] = 1'b1;
            seen1[dbg1] = 1'b1;
        end
        if (m_en) begin
            if (!in_burst) begin
                gap_q.push_back(idle_run);
                run_len = 0;
                er_run = 0;
                in_burst = 1;
            end
            byte_q.push_back(m_txd);
            run_len++;
            if (m_er) er_run++;
            idle_run = 0;
        end else begin
            if (m_er) stray_er++;
            if (in_burst) begin
                len_q.push_back(run_len);
                er_q.push_back(er_run);
                in_burst = 0;
            end
            idle_run++;
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0, bad = 0;
    logic [31:0] lut [256];
    logic [7:0]  pay_q[$];
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    logic [31:0] exp_fcs_q[$];
    logic [31:0] fcs_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Wire image of one good frame: preamble, SFD, payload, pad, FCS.
    task automatic build_expected(input int min_frame);
        logic [31:0] c;
        logic [7:0]  b;
        int n, tot;
        c = 32'hFFFF_FFFF;
        n = pay_q.size();
        tot = (n > min_frame) ? n : min_frame;
        for (int k = 0; k < PRE; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < tot; k++) begin
            b = (k < n) ? pay_q[k] : 8'h00;
            exp_q.push_back(b);
            c = lut[c[7:0] ^ b] ^ (c >> 8);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        exp_len_q.push_back(PRE + 1 + tot + 4);
        exp_fcs_q.push_back(c);
    endtask

    task automatic check_frame(input string tag, input int want_gap, input int want_er,
                               output logic [31:0] tail);
        int len, er, gap, exp_len, mism, guard;
        logic [31:0] want_fcs;
        logic [7:0]  b;
        tail = 32'd0;
        guard = 0;
        while (len_q.size() == 0 && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        exp_len = exp_len_q.pop_front();
        want_fcs = exp_fcs_q.pop_front();
        if (len_q.size() == 0) begin
            check({tag, "_timeout"}, len_q.size(), 1);
            for (int k = 0; k < exp_len; k++) void'(exp_q.pop_front());
            return;
        end
        len = len_q.pop_front();
        er  = er_q.pop_front();
        gap = gap_q.pop_front();
        mism = 0;
        for (int k = 0; k < len; k++) begin
            b = byte_q.pop_front();
            if (k >= exp_len || b !== exp_q[k]) mism++;
            if (k >= len - 4) tail = {b, tail[31:8]};
        end
        for (int k = 0; k < exp_len; k++) void'(exp_q.pop_front());
        check({tag, "_len"}, len, exp_len);
        check({tag, "_er"}, er, want_er);
        check({tag, "_bytes_bad"}, mism, 0);
        check({tag, "_fcs"}, tail, want_fcs);
        if (want_gap >= 0) check({tag, "_gap"}, gap, want_gap);
    endtask

    // ---------------- driver tasks ----------------
    // Presents pay_q; drop_after inserts one idle cycle before that byte
    // index, stop_at returns before presenting that byte index.
    task automatic drive_frame(input int drop_after, input int stop_at);
        int i, guard;
        logic acc;
        bit dropped;
        i = 0;
        guard = 0;
        dropped = 0;
        while (i < pay_q.size()) begin
            if (i == stop_at) return;
            if (i == drop_after && !dropped) begin
                s_tvalid = 1'b0;
                dropped = 1;
                @(posedge clk); #1;
            end else begin
                s_tdata  = pay_q[i];
                s_tlast  = (i == pay_q.size() - 1);
                s_tvalid = 1'b1;
                @(negedge clk);
                acc = m_ready;
                @(posedge clk); #1;
                if (acc) i++;
            end
            guard++;
            if (guard > 3000) begin
                check("drive_timeout", i, pay_q.size());
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic quiet_ready(input string tag, input int n);
        int cnt;
        cnt = 0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (m_ready) cnt++;
            @(posedge clk); #1;
        end
        check(tag, cnt, 0);
    endtask

    task automatic rand_payload(input int n);
        pay_q.delete();
        for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) lut[i] = crc_step(32'(i), 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("rst_en1", {31'b0, en1}, 0);
        check("rst_er1", {31'b0, er1}, 0);
        check("rst_txd1", {24'b0, txd1}, 0);
        check("rst_ready1", {31'b0, ready1}, 0);
        check("rst_crc1", cstate1, 32'hFFFF_FFFF);
        check("rst_en0", {31'b0, en0}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Check vector on the unpadded instance, sent twice back to back.
        sel = 1'b0;
        pay_q.delete();
        for (int k = 0; k < 9; k++) pay_q.push_back(8'h31 + 8'(k));
        build_expected(0);
        drive_frame(-1, -1);
        build_expected(0);
        drive_frame(-1, -1);
        idle(5);
        check_frame("cv_a", -1, 0, fcs_seen);
        check("cv_fcs_const", fcs_seen, 32'hCBF43926);
        check_frame("cv_b", IFG, 0, fcs_seen);
        idle(20);

        // Exact-minimum frame, no padding; s_tready stays low through FCS/IFG.
        sel = 1'b1;
        idle(2);
        pay_q.delete();
        for (int k = 0; k < 60; k++) pay_q.push_back(8'(k));
        build_expected(MINF);
        drive_frame(-1, -1);
        quiet_ready("ready_fcs_ifg", 14);
        check_frame("min60", -1, 0, fcs_seen);
        idle(5);

        // Short frames: 14 bytes and a single tlast-on-first byte.
        rand_payload(14);
        build_expected(MINF);
        drive_frame(-1, -1);
        quiet_ready("ready_pad", 20);
        check_frame("short14", -1, 0, fcs_seen);
        idle(5);
        rand_payload(1);
        build_expected(MINF);
        drive_frame(-1, -1);
        idle(2);
        check_frame("short1", -1, 0, fcs_seen);
        idle(5);

        // Back to back 100-byte frames with s_tvalid held.
        rand_payload(100);
        build_expected(MINF);
        drive_frame(-1, -1);
        rand_payload(100);
        build_expected(MINF);
        drive_frame(-1, -1);
        idle(2);
        check_frame("b2b_a", -1, 0, fcs_seen);
        check_frame("b2b_b", IFG, 0, fcs_seen);
        idle(20);

        // Underflow after byte 30 of 50, next frame queued immediately.
        rand_payload(50);
        for (int k = 0; k < PRE; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < 30; k++) exp_q.push_back(pay_q[k]);
        exp_q.push_back(8'h00);
        exp_len_q.push_back(PRE + 1 + 30 + 1);
        exp_fcs_q.push_back({8'h00, pay_q[29], pay_q[28], pay_q[27]});
        drive_frame(30, -1);
        rand_payload(70);
        build_expected(MINF);
        drive_frame(-1, -1);
        idle(2);
        check_frame("underflow", -1, 1, fcs_seen);
        check_frame("after_uf", 20 + IFG, 0, fcs_seen);
        idle(20);

        // Random lengths and idle spacing.
        for (int r = 0; r < 4; r++) begin
            rand_payload($urandom_range(1, 130));
            build_expected(MINF);
            drive_frame(-1, -1);
            idle($urandom_range(0, 20));
        end
        idle(2);
        for (int r = 0; r < 4; r++) check_frame($sformatf("rand%0d", r), -1, 0, fcs_seen);
        idle(20);

        // Reset while byte 20 of the payload is on the bus.
        rand_payload(40);
        drive_frame(-1, 19);
        s_tdata  = pay_q[19];
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        reset    = 1'b1;
        @(posedge clk); #1;
        check("midrst_en", {31'b0, en1}, 0);
        check("midrst_txd", {24'b0, txd1}, 0);
        check("midrst_ready", {31'b0, ready1}, 0);
        check("midrst_crc", cstate1, 32'hFFFF_FFFF);
        reset = 1'b0;
        idle(3);
        byte_q.delete();
        len_q.delete();
        gap_q.delete();
        er_q.delete();
        rand_payload(25);
        build_expected(MINF);
        drive_frame(-1, -1);
        idle(2);
        check_frame("post_rst", -1, 0, fcs_seen);
        idle(20);

        check("stray_er", stray_er, 0);
        check("extra_bursts", len_q.size(), 0);
        check("states_dut0", $countones(seen0), 5);
        check("states_dut1", $countones(seen1), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
